// File: rtl/speed_sel.sv
// ============================================================================
// speed_sel: two debounced buttons adjust an 8-bit divider value with
// press-and-hold auto-repeat; pressing both buttons restores the default.
// Revision: 1.0
// ============================================================================
`default_nettype none

module speed_sel #(
  parameter int         DEB_CYCLES    = 50000,
  parameter int         REPEAT_DELAY  = 500000,
  parameter int         REPEAT_PERIOD = 200000,
  parameter logic [7:0] DEF_VAL       = 8'd16,
  parameter logic [7:0] MIN_VAL       = 8'd1,
  parameter logic [7:0] MAX_VAL       = 8'd255,
  parameter logic [7:0] STEP          = 8'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] divval,
  output logic       update
);

  localparam int MAX_AB = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  // Bit 0 is the "up" button, bit 1 the "down" button.
  logic [1:0] raw;
  logic [1:0] deb;
  logic [1:0] rise;

  assign raw = {btn_down, btn_up};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_deb
      logic          sync1;
      logic          sync2;
      logic          level;
      logic          rise_r;
      logic [CW-1:0] cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1  <= 1'b0;
          sync2  <= 1'b0;
          level  <= 1'b0;
          rise_r <= 1'b0;
          cnt    <= '0;
        end else begin
          sync1 <= raw[i];
          sync2 <= sync1;
          if (sync2 != level) begin
            if (cnt == DEB_LAST) begin
              level  <= sync2;
              rise_r <= sync2;
              cnt    <= '0;
            end else begin
              rise_r <= 1'b0;
              cnt    <= cnt + 1'b1;
            end
          end else begin
            rise_r <= 1'b0;
            cnt    <= '0;
          end
        end
      end

      assign deb[i]  = level;
      assign rise[i] = rise_r;
    end
  endgenerate

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          dir;        // 1 = up button is the one being held
  logic          dir_nxt;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] rcnt_nxt;

  logic both_hi;
  logic held;

  assign both_hi = deb[0] & deb[1];
  assign held    = dir ? deb[0] : deb[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      dir   <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    rcnt_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (rise != 2'b00) begin
          if (both_hi) begin
            state_nxt = S_LOCK;
          end else begin
            state_nxt = S_DELAY;
            dir_nxt   = rise[0];
          end
        end
      end
      S_DELAY: begin
        if (both_hi) begin
          state_nxt = S_LOCK;
        end else if (!held) begin
          state_nxt = S_IDLE;
        end else if (rcnt == RD_LAST) begin
          state_nxt = S_REPEAT;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      S_REPEAT: begin
        if (both_hi) begin
          state_nxt = S_LOCK;
        end else if (!held) begin
          state_nxt = S_IDLE;
        end else if (rcnt != RP_LAST) begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      default: begin
        if (deb == 2'b00) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  logic step_req;
  logic step_up;
  logic lock_req;

  always_comb begin
    step_req = 1'b0;
    step_up  = dir;
    lock_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise != 2'b00) begin
          lock_req = both_hi;
          step_req = !both_hi;
          step_up  = rise[0];
        end
      end
      S_DELAY: begin
        lock_req = both_hi;
        step_req = !both_hi && held && (rcnt == RD_LAST);
      end
      S_REPEAT: begin
        lock_req = both_hi;
        step_req = !both_hi && held && (rcnt == RP_LAST);
      end
      default: begin
        lock_req = 1'b0;
      end
    endcase
  end

  // Nine-bit arithmetic exposes the borrow/carry so results clamp instead of wrapping.
  logic [8:0] dec;
  logic [8:0] inc;
  logic [7:0] step_val;

  assign dec = {1'b0, divval} - {1'b0, STEP};
  assign inc = {1'b0, divval} + {1'b0, STEP};

  always_comb begin
    step_val = divval;
    if (step_up) begin
      step_val = (dec[8] || (dec[7:0] < MIN_VAL)) ? MIN_VAL : dec[7:0];
    end else begin
      step_val = (inc > {1'b0, MAX_VAL}) ? MAX_VAL : inc[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divval <= DEF_VAL;
      update <= 1'b0;
    end else if (lock_req) begin
      divval <= DEF_VAL;
      update <= (divval != DEF_VAL);
    end else if (step_req) begin
      divval <= step_val;
      update <= (divval != step_val);
    end else begin
      update <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/speed_sel.md
SPEED_SEL -- requirements
Module: speed_sel

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-high.
REQ-002 Parameter DEB_CYCLES, default 50000, SHALL set the number of consecutive stable cycles required to accept a button level change.
REQ-003 Parameter REPEAT_DELAY, default 500000, SHALL set the cycles from accepted press to first auto-repeat step.
REQ-004 Parameter REPEAT_PERIOD, default 200000, SHALL set the cycles between subsequent auto-repeat steps.
REQ-005 Parameters DEF_VAL, MIN_VAL, MAX_VAL and STEP, defaults 8'd16, 8'd1, 8'd255 and 8'd1, SHALL set the reset, lower-bound, upper-bound and increment values of divval.
REQ-006 Port clock, input, 1: system clock; all state is updated on its rising edge.
REQ-007 Port reset, input, 1: asynchronous active-high reset.
REQ-008 Port btn_up, input, 1: raw asynchronous bouncing "faster" button, high = pressed.
REQ-009 Port btn_down, input, 1: raw asynchronous bouncing "slower" button, high = pressed.
REQ-010 Port divval, output, 8: registered division value driving the downstream frequency divider's 8-bit data input.
REQ-011 Port update, output, 1: registered one-cycle pulse, high in the cycle that divval takes a new value.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each button SHALL have an independent debouncer: the debounced level flips only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any return to the old level clears the counter.
REQ-014 Debouncer counters SHALL be wide enough for the largest of DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD and SHALL never wrap.
REQ-015 The control FSM SHALL have states IDLE, DELAY, REPEAT and LOCK.
REQ-016 In IDLE, a debounced rise of exactly one button SHALL apply one step in the next cycle and move to DELAY with the repeat counter cleared.
REQ-017 In DELAY, after REPEAT_DELAY cycles with the same button still held, the FSM SHALL apply one step and move to REPEAT.
REQ-018 In REPEAT, every REPEAT_PERIOD cycles while the button is held, the FSM SHALL apply one step.
REQ-019 In DELAY or REPEAT, release of the held button SHALL return the FSM to IDLE with no further step.
REQ-020 If both debounced levels are high, whether rising in the same cycle or with the second rising while the first is held, the FSM SHALL load divval with DEF_VAL and enter LOCK.
REQ-021 In LOCK, the FSM SHALL ignore both buttons until both are debounced low, then return to IDLE.
REQ-022 An up step SHALL compute divval - STEP, and a down step SHALL compute divval + STEP, with a 9-bit intermediate.
REQ-023 A step result SHALL saturate to MIN_VAL and MAX_VAL, and SHALL never wrap.
REQ-024 update SHALL pulse only when the registered divval actually changes; a saturated step with no change produces no pulse.
REQ-025 Latency from a clean raw edge to the divval change SHALL be 2 + DEB_CYCLES + 1 cycles.

Reset
REQ-026 While reset is high, divval SHALL be DEF_VAL, update SHALL be 0, the FSM SHALL be in IDLE, and synchronizers, debounced levels and all counters SHALL be 0, all independent of clock.
REQ-027 Reset asserted mid-repeat SHALL take effect immediately.
REQ-028 After reset is released, a button that is still held SHALL be treated as a new press once it is debounced.

Verification (DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, defaults otherwise)
REQ-029 Reset, then idle 20 cycles -> divval=16, update never high.
REQ-030 Clean btn_up press held 6 cycles then released -> divval 16 to 15 exactly 7 cycles after the press edge, one update pulse, no repeat.
REQ-031 btn_down held continuously -> divval 17 at cycle 7, then 18 at cycle 15, 19 at cycle 19, 20 at cycle 23, 21 at cycle 27.
REQ-032 btn_up toggled every 2 cycles for 20 cycles, then released -> divval stays 16, no update.
REQ-033 From divval=1, press btn_up -> no change, no update; from divval=255, press btn_down -> no change, no update.
REQ-034 From divval=20, hold btn_up and press btn_down while btn_up is still held -> divval=16 with a single update, further holds ignored until both are released, and a subsequent btn_down press gives 17.
